// File: rtl/tick_pkg.sv
// tick_pkg: shared states, mode encodings and limits for the multi-channel tick generator
package tick_pkg;
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;
    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;
    localparam int unsigned MAX_CHANNELS = 16;
endpackage

// File: rtl/tick_channel.sv
// tick_channel: one down-counter with period register, run/idle FSM and registered tick
module tick_channel
    import tick_pkg::*;
#(
    parameter int unsigned Width = 30
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cfg_we_i,
    input  logic [Width-1:0] k_i,
    input  logic             mode_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             en_i,
    output logic             tick_o,
    output logic             busy_o,
    output logic             tick_cond_o
);
    state_e state_q, state_d;
    logic [Width-1:0] period_q, period_d, cnt_q, cnt_d;
    logic mode_q, mode_d, tick_q, run, zero;
    always_comb begin
        run = state_q == RUN;
        zero = cnt_q == '0;
        // stop and start both override the count path, so neither may tick
        tick_cond_o = run & en_i & ~start_i & ~stop_i & zero;
        state_d = stop_i ? IDLE : start_i ? RUN : (tick_cond_o && mode_q == MODE_ONESHOT) ? IDLE : state_q;
        cnt_d = stop_i ? cnt_q
              : start_i ? (cfg_we_i ? k_i : period_q)
              : (run && en_i) ? (zero ? period_q : cnt_q - Width'(1))
              : cnt_q;
        mode_d = (start_i && !stop_i) ? mode_i : mode_q;
        period_d = cfg_we_i ? k_i : period_q;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            period_q <= '0;
            cnt_q <= '0;
            mode_q <= MODE_PERIODIC;
            tick_q <= 1'b0;
        end else begin
            state_q <= state_d;
            period_q <= period_d;
            cnt_q <= cnt_d;
            mode_q <= mode_d;
            tick_q <= tick_cond_o;
        end
    end
    assign tick_o = tick_q;
    assign busy_o = state_q == RUN;
endmodule

// File: rtl/multi_tick_gen.sv
// multi_tick_gen: bank of independent tick channels with global sync restart and merged tick
module multi_tick_gen
    import tick_pkg::*;
#(
    parameter int unsigned Width    = 30,
    parameter int unsigned Channels = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [Channels-1:0]       cfg_we_i,
    input  logic [Channels*Width-1:0] k_i,
    input  logic [Channels-1:0]       mode_i,
    input  logic [Channels-1:0]       start_i,
    input  logic [Channels-1:0]       stop_i,
    input  logic                      sync_i,
    input  logic [Channels-1:0]       en_i,
    output logic [Channels-1:0]       tick_o,
    output logic [Channels-1:0]       busy_o,
    output logic                      any_tick_o
);
    logic [Channels-1:0] tick_cond;
    logic any_tick_q;
    if (Channels < 1 || Channels > MAX_CHANNELS) begin : g_bad_channels
        $error("multi_tick_gen: Channels out of range");
    end
    for (genvar c = 0; c < Channels; c++) begin : g_ch
        tick_channel #(.Width(Width)) u_ch (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .cfg_we_i    (cfg_we_i[c]),
            .k_i         (k_i[c*Width +: Width]),
            .mode_i      (mode_i[c]),
            .start_i     (start_i[c] | sync_i),
            .stop_i      (stop_i[c]),
            .en_i        (en_i[c]),
            .tick_o      (tick_o[c]),
            .busy_o      (busy_o[c]),
            .tick_cond_o (tick_cond[c])
        );
    end
    // registered from the raw conditions so it lines up with every tick_o bit
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) any_tick_q <= 1'b0;
        else any_tick_q <= |tick_cond;
    end
    assign any_tick_o = any_tick_q;
endmodule

// File: doc/multi_tick_gen.md
# multi_tick_gen

Multi-channel, parametrised tick generator: each of `Channels` independent down-counters emits a one-cycle tick every `period+1` enabled cycles, in periodic or one-shot mode. Supports per-channel programmable period, start/stop control and a global phase-sync restart. It is the successor of the single-channel clock-divider tick. It sits between the system clock and the single-tick consumers (debouncers, UART baud, LED blinkers), providing all time bases from one block.

## Interface
- `Width`, 30, counter/period width per channel
- `Channels`, 4, number of independent channels (1..16)

- `clk_i`  in  1  system clock, all logic on rising edge
- `rst_ni`  in  1  asynchronous active-low reset
- `cfg_we_i`  in  Channels  per-channel period write strobe
- `k_i`  in  Channels*Width  period values; channel c uses slice [c*Width +: Width]
- `mode_i`  in  Channels  per-channel mode, sampled at start: 0 periodic, 1 one-shot
- `start_i`  in  Channels  per-channel start/restart pulse
- `stop_i`  in  Channels  per-channel stop pulse
- `sync_i`  in  1  global restart: acts as `start_i` on every channel
- `en_i`  in  Channels  per-channel count enable (prescaler input)
- `tick_o`  out  Channels  one-cycle tick per channel, registered
- `busy_o`  out  Channels  channel is in RUN
- `any_tick_o`  out  1  registered OR of all tick conditions

## Operation
Per-channel state:
- `period_q` (Width)
- `cnt_q` (Width)
- `mode_q`
- state IDLE/RUN

Reset: all registers 0 and all channels IDLE. `tick_o`, `busy_o` and `any_tick_o` are 0.

Config:
- `cfg_we_i[c]` loads `period_q` from the k slice in any state.
- A write does not alter a running `cnt_q`. The new period applies at the next reload.

Per-channel priority each cycle: stop > start > count.
- **stop**: next state is IDLE and `cnt_q` holds. Any tick condition in the same cycle is suppressed.
- **start** (`start_i[c] | sync_i`):
  - next state is RUN and `mode_q` ← `mode_i[c]`.
  - `cnt_q` ← period, where period = k slice if `cfg_we_i[c]` is asserted in the same cycle, else `period_q`.
  - Start while RUN restarts the channel and suppresses any tick in that cycle.
- **count** (RUN and `en_i[c]`):
  - If `cnt_q == 0`, this is a tick condition. `cnt_q` ← `period_q` (reload).
  - On a tick condition with `mode_q == 1`, next state is IDLE.
  - Otherwise `cnt_q` ← `cnt_q - 1`.
- RUN with `en_i[c] = 0`: `cnt_q` holds and no tick.
- IDLE: `cnt_q` holds, `en_i` is ignored, and no tick.

Arithmetic: decrement is modulo 2^Width but never underflows, because zero always reloads. Period 0 means a tick on every enabled cycle.

## Timing
- Tick latency: `tick_o[c]` goes high the cycle after the tick condition, for exactly 1 cycle per condition.
- Periodic spacing: with `en_i` held high and period P, start at edge t0 gives ticks visible after edges t0+P+2, t0+2P+3, and so on. The spacing is P+1 cycles.
- One-shot:
  - Exactly one tick; `busy_o` drops on the same edge that registers the tick.
  - A re-start is accepted the cycle after.
- `busy_o` is a direct register output and reflects RUN one cycle after start.
- `sync_i` aligns all channels that receive it to the same edge. Channels with equal periods then tick on identical cycles.
- Async reset mid-count clears everything immediately. There is no tick on reset release, and channels stay IDLE until started.
- `any_tick_o` is coincident with `tick_o`: same cycle, registered.

## Structure
- Package `tick_pkg`:
  - state enum (IDLE, RUN)
  - mode constants (MODE_PERIODIC = 0, MODE_ONESHOT = 1)
  - max `Channels` constant
- Sub-module `tick_channel`, parametrised by `Width`: one counter, period register, mode, FSM and tick flop.
- `multi_tick_gen` generates `Channels` instances, slices `k_i`, fans out `sync_i` and builds `any_tick_o`.

## Test plan
- **Reset defaults**: assert `rst_ni` = 0 mid-count with period 5 → all outputs 0 immediately. After release with no start, no tick for 20 cycles.
- **Periodic**: ch0 with period 3 loaded, start, `en_i` = 1 → ticks exactly 4 cycles apart, the first 5 cycles after the start edge, with `busy_o` = 1 throughout.
- **One-shot**: ch1 with period 2, `mode_i` = 1, start → a single tick 4 cycles after start, `busy_o` falls with it, and no further ticks in 20 cycles.
- **Enable gating and period 0**:
  - ch2 with period 0 and `en_i` toggling 1,0,1,0 → a tick only after enabled cycles.
  - ch2 with `en_i` = 0 for 10 cycles → `cnt_q` frozen and no tick.
- **Priority and mid-run reconfig**:
  - ch0 running with period 3: write period 7 → the current interval ends at 3, then the next intervals use 7.
  - Simultaneous `start_i` + `stop_i` → IDLE.
  - Start + `cfg_we_i` in one cycle → the counter uses the new k.
- **Sync**: ch0..3 with periods 4, 4, 9, 4 started at different times, then pulse `sync_i` → ch0, ch1 and ch3 tick on identical cycles; `any_tick_o` equals the OR of `tick_o` every cycle.
